serial_adder: RTL and testbench

Bit-serial N-bit adder built around a single one-bit full-adder cell plus a carry flip-flop. It consumes one operand bit pair per clock, LSB first. It produces the full N-bit sum and final carry after N cycles. It sits directly upstream of the full-adder cell: it sequences the cell's A/B/carry_in inputs and registers its SUM/carry_out outputs. This trades area for latency against a ripple-carry adder.

---
 rtl/serial_adder.sv | 79 +++++++
 tb/tb_serial_adder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell plus a carry flip-flop, LSB first.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry_reg;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-2:0] shift_r;
  logic             fa_sum;
  logic             fa_co;
  always_comb begin
    fa_sum = shift_a[0] ^ shift_b[0] ^ carry_reg;
    fa_co  = (shift_a[0] & shift_b[0]) | (carry_reg & (shift_a[0] ^ shift_b[0]));
  end
  // shift_r collects the first WIDTH-1 sum bits; the last bit joins it on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      cnt       <= '0;
      carry_reg <= 1'b0;
      shift_a   <= '0;
      shift_b   <= '0;
      shift_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shift_a   <= a;
            shift_b   <= b;
            carry_reg <= carry_in;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          shift_a   <= shift_a >> 1;
          shift_b   <= shift_b >> 1;
          shift_r   <= (WIDTH-1)'({fa_sum, shift_r} >> 1);
          carry_reg <= fa_co;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum       <= {fa_sum, shift_r};
            carry_out <= fa_co;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: vector table, corner sequences and random ops against a+b+cin for WIDTH 8 and 16.
module tb_serial_adder;
  logic        clk, rst;
  logic        start8, ci8, busy8, done8, co8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, ci16, busy16, done16, co16;
  logic [15:0] a16, b16, sum16;
  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .carry_in(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8)
  );
  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .carry_in(ci16),
    .busy(busy16), .done(done16), .sum(sum16), .carry_out(co16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // result holds from one done pulse to the next unless reset intervenes; done never lasts two cycles
  logic        mon_rst;
  logic        pd8, pd16;
  logic [8:0]  prev8;
  logic [16:0] prev16;
  always @(posedge clk) begin
    mon_rst = rst;
    #1;
    if (!mon_rst && !done8) chk("sum8_stable", 33'({co8, sum8}), 33'(prev8));
    if (!mon_rst && !done16) chk("sum16_stable", 33'({co16, sum16}), 33'(prev16));
    if (done8 && pd8) chk("done8_width", 33'(1), 33'(0));
    if (done16 && pd16) chk("done16_width", 33'(1), 33'(0));
    prev8  = {co8, sum8};
    prev16 = {co16, sum16};
    pd8    = done8;
    pd16   = done16;
  end

  task automatic do_op(input int w, input logic [31:0] x, input logic [31:0] y, input logic c,
                       output logic [32:0] res, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    @(negedge clk);
    if (w == 8) begin start8 = 1'b1; a8 = x[7:0]; b8 = y[7:0]; ci8 = c; end
    else begin start16 = 1'b1; a16 = x[15:0]; b16 = y[15:0]; ci16 = c; end
    @(posedge clk);
    #1;
    if ((w == 8) ? busy8 : busy16) bcnt++;
    @(negedge clk);
    start8 = 1'b0;
    start16 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if ((w == 8) ? done8 : done16) begin
        lat = i;
        break;
      end
      if ((w == 8) ? busy8 : busy16) bcnt++;
    end
    res = (w == 8) ? 33'({co8, sum8}) : 33'({co16, sum16});
    if (lat == 0) chk("done_timeout", 33'(0), 33'(w));
    @(posedge clk);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
  } vec_t;
  vec_t vecs[5];

  logic [32:0] res;
  logic [32:0] exp;
  logic [31:0] x, y;
  logic        c;
  int          lat, bcnt;

  initial begin
    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset8", 33'({busy8, done8, co8, sum8}), 33'(0));
    chk("reset16", 33'({busy16, done16, co16, sum16}), 33'(0));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_op(8, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].c, res, lat, bcnt);
      chk($sformatf("vec%0d_sum", i), 33'(res[7:0]), 33'(vecs[i].s));
      chk($sformatf("vec%0d_co", i), 33'(res[8]), 33'(vecs[i].co));
      chk($sformatf("vec%0d_lat", i), 33'(lat), 33'(8));
      chk($sformatf("vec%0d_busy", i), 33'(bcnt), 33'(8));
    end

    // start held high: operands after accept are ignored, next accept lands on the first IDLE edge
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_accept", 33'(busy8), 33'(1));
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      a8 = 8'(i * 3); b8 = 8'(i * 5); ci8 = i[0];
      @(posedge clk);
      #1;
      if (i == 8) chk("hold_first", 33'({done8, co8, sum8}), 33'({1'b1, 1'b0, 8'h30}));
      if (i == 9) chk("hold_idle", 33'({busy8, done8}), 33'(0));
      if (i == 10) chk("hold_reaccept", 33'(busy8), 33'(1));
    end
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk);
      #1;
      if (done8) begin lat = j; break; end
    end
    chk("hold_second_lat", 33'(lat), 33'(8));
    chk("hold_second_sum", 33'({co8, sum8}), 33'(9'h050));
    @(posedge clk);

    // reset four cycles into an operation abandons it
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_outputs", 33'({busy8, done8, co8, sum8}), 33'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_done", 33'({busy8, done8}), 33'(0));
    end
    do_op(8, 32'h12, 32'h34, 1'b0, res, lat, bcnt);
    chk("after_rst_sum", res, 33'h046);

    // reset beats a simultaneous start
    @(negedge clk);
    rst = 1'b1; start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
    @(posedge clk);
    #1;
    chk("rst_vs_start", 33'({busy8, done8, co8, sum8}), 33'(0));
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_vs_start_idle", 33'(busy8), 33'(0));

    for (int n = 0; n < 1000; n++) begin
      x = $urandom; y = $urandom; c = 1'($urandom_range(0, 1));
      exp = 33'(x[7:0]) + 33'(y[7:0]) + 33'(c);
      do_op(8, x, y, c, res, lat, bcnt);
      chk("rand8_sum", res, exp);
      chk("rand8_lat", 33'(lat), 33'(8));
    end
    for (int n = 0; n < 1000; n++) begin
      x = $urandom; y = $urandom; c = 1'($urandom_range(0, 1));
      exp = 33'(x[15:0]) + 33'(y[15:0]) + 33'(c);
      do_op(16, x, y, c, res, lat, bcnt);
      chk("rand16_sum", res, exp);
      chk("rand16_lat", 33'(lat), 33'(16));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
